// File: rtl/cpu_control_pkg.sv
// -----------------------------------------------------------------------------
// cpu_control_pkg
// Shared constants and types for the multicycle RISC-V main control FSM:
//   - the four supported opcode values (lw, sw, R-type, beq)
//   - the FSM state enum (4-bit encoding, unused codes recover to FETCH)
//   - ALUOp and ALUSrcB encodings driven onto the datapath
//   - a packed bundle of every control output, plus small decode helpers
// -----------------------------------------------------------------------------
package cpu_control_pkg;

  // Opcode field values, instruction[6:0]
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // Control FSM states. Codes 4'd9..4'd15 are unused and must never persist.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    RTYPE_WB = 4'd7,
    BRANCH   = 4'd8
  } state_e;

  // ALU operation requested from the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // Second ALU operand select
  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10,
    SRCB_BOFF = 2'b11
  } srcb_e;

  // Every control line driven to the datapath, in one bundle so the
  // output decode can start from an all-zero default.
  typedef struct packed {
    logic       mem_read;
    logic       alu_src_a;
    logic       i_or_d;
    logic       ir_write;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_source;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_write;
    logic       pc_write_cond;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    mem_read:      1'b0,
    alu_src_a:     1'b0,
    i_or_d:        1'b0,
    ir_write:      1'b0,
    alu_src_b:     2'b00,
    alu_op:        2'b00,
    pc_write:      1'b0,
    pc_source:     1'b0,
    mem_to_reg:    1'b0,
    reg_write:     1'b0,
    reg_dst:       1'b0,
    mem_write:     1'b0,
    pc_write_cond: 1'b0
  };

  // True for the opcodes that go through the address-calculation state
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  // Next state out of DECODE for a given opcode; unsupported opcodes
  // are no-ops and go straight back to FETCH.
  function automatic state_e decode_next(input logic [6:0] op);
    state_e nxt;
    if (is_mem_op(op)) begin
      nxt = MEMADR;
    end else if (op == OP_RTYPE) begin
      nxt = EXECUTE;
    end else if (op == OP_BEQ) begin
      nxt = BRANCH;
    end else begin
      nxt = FETCH;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cpu_control.sv
// -----------------------------------------------------------------------------
// cpu_control
// Multicycle RISC-V main control FSM (lw, sw, R-type, beq). One state per
// clock; outputs are a Moore decode of the state register and are all forced
// to 0 while rst is high.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset (-> FETCH)
//   OPCode[6:0]  in   instruction[6:0] from the IR, sampled leaving DECODE/MEMADR
//   MemRead      out  memory read enable
//   ALUSrcA      out  0=PC, 1=register A
//   IorD         out  memory address: 0=PC, 1=ALUOut
//   IRWrite      out  instruction register load
//   ALUSrcB[1:0] out  00=B, 01=4, 10=imm, 11=branch offset imm
//   ALUOp[1:0]   out  00=add, 01=sub/compare, 10=funct
//   PCWrite      out  unconditional PC load
//   PCSource     out  0=ALU result, 1=ALUOut
//   MemToReg     out  0=ALUOut, 1=MDR
//   RegWrite     out  register file write enable
//   RegDst       out  0=lw rd path, 1=R-type rd path
//   MemWrite     out  memory write enable
//   PCWriteCond  out  PC load qualified by ALU zero
// -----------------------------------------------------------------------------
module cpu_control
  import cpu_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] OPCode,
  output logic       MemRead,
  output logic       ALUSrcA,
  output logic       IorD,
  output logic       IRWrite,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       PCWrite,
  output logic       PCSource,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemWrite,
  output logic       PCWriteCond
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_s;

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; OPCode is only consulted leaving DECODE and MEMADR
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE:   state_d = decode_next(OPCode);
      MEMADR: begin
        // The IR is stable, but guard against anything other than lw/sw
        // so the FSM can never stall in an address state.
        if (OPCode == OP_LW) begin
          state_d = MEMREAD;
        end else if (OPCode == OP_SW) begin
          state_d = MEMWRITE;
        end else begin
          state_d = FETCH;
        end
      end
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECUTE:  state_d = RTYPE_WB;
      RTYPE_WB: state_d = FETCH;
      BRANCH:   state_d = FETCH;
      default:  state_d = FETCH;  // unused encodings recover
    endcase
  end

  // Moore output decode; reset overrides the state so the datapath sees
  // no enables while rst is held, even before the first clock edge.
  always_comb begin
    ctrl_s = CTRL_IDLE;
    if (rst) begin
      ctrl_s = CTRL_IDLE;
    end else begin
      case (state_q)
        FETCH: begin
          ctrl_s.mem_read  = 1'b1;
          ctrl_s.i_or_d    = 1'b0;
          ctrl_s.ir_write  = 1'b1;
          ctrl_s.alu_src_a = 1'b0;
          ctrl_s.alu_src_b = SRCB_FOUR;
          ctrl_s.alu_op    = ALUOP_ADD;
          ctrl_s.pc_write  = 1'b1;
          ctrl_s.pc_source = 1'b0;
        end
        DECODE: begin
          // Speculatively compute the branch target into ALUOut
          ctrl_s.alu_src_a = 1'b0;
          ctrl_s.alu_src_b = SRCB_BOFF;
          ctrl_s.alu_op    = ALUOP_ADD;
        end
        MEMADR: begin
          ctrl_s.alu_src_a = 1'b1;
          ctrl_s.alu_src_b = SRCB_IMM;
          ctrl_s.alu_op    = ALUOP_ADD;
        end
        MEMREAD: begin
          ctrl_s.mem_read = 1'b1;
          ctrl_s.i_or_d   = 1'b1;
        end
        MEMWB: begin
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.mem_to_reg = 1'b1;
          ctrl_s.reg_dst    = 1'b0;
        end
        MEMWRITE: begin
          ctrl_s.mem_write = 1'b1;
          ctrl_s.i_or_d    = 1'b1;
        end
        EXECUTE: begin
          ctrl_s.alu_src_a = 1'b1;
          ctrl_s.alu_src_b = SRCB_REG;
          ctrl_s.alu_op    = ALUOP_FUNCT;
        end
        RTYPE_WB: begin
          ctrl_s.reg_write  = 1'b1;
          ctrl_s.reg_dst    = 1'b1;
          ctrl_s.mem_to_reg = 1'b0;
        end
        BRANCH: begin
          ctrl_s.alu_src_a     = 1'b1;
          ctrl_s.alu_src_b     = SRCB_REG;
          ctrl_s.alu_op        = ALUOP_SUB;
          ctrl_s.pc_write_cond = 1'b1;
          ctrl_s.pc_source     = 1'b1;
        end
        default: begin
          ctrl_s = CTRL_IDLE;
        end
      endcase
    end
  end

  assign MemRead     = ctrl_s.mem_read;
  assign ALUSrcA     = ctrl_s.alu_src_a;
  assign IorD        = ctrl_s.i_or_d;
  assign IRWrite     = ctrl_s.ir_write;
  assign ALUSrcB     = ctrl_s.alu_src_b;
  assign ALUOp       = ctrl_s.alu_op;
  assign PCWrite     = ctrl_s.pc_write;
  assign PCSource    = ctrl_s.pc_source;
  assign MemToReg    = ctrl_s.mem_to_reg;
  assign RegWrite    = ctrl_s.reg_write;
  assign RegDst      = ctrl_s.reg_dst;
  assign MemWrite    = ctrl_s.mem_write;
  assign PCWriteCond = ctrl_s.pc_write_cond;

endmodule

// File: tb/tb_cpu_control.sv
// -----------------------------------------------------------------------------
// tb_cpu_control
// Table-driven, scoreboard-checked bench for the multicycle control FSM.
// Output vector packing (MSB first):
//   MemRead ALUSrcA IorD IRWrite ALUSrcB[1:0] ALUOp[1:0] PCWrite PCSource
//   MemToReg RegWrite RegDst MemWrite PCWriteCond
// -----------------------------------------------------------------------------
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] OPCode;
  logic       MemRead, ALUSrcA, IorD, IRWrite;
  logic [1:0] ALUSrcB, ALUOp;
  logic       PCWrite, PCSource, MemToReg, RegWrite, RegDst, MemWrite, PCWriteCond;

  cpu_control dut (
    .clk        (clk),
    .rst        (rst),
    .OPCode     (OPCode),
    .MemRead    (MemRead),
    .ALUSrcA    (ALUSrcA),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCWrite    (PCWrite),
    .PCSource   (PCSource),
    .MemToReg   (MemToReg),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemWrite   (MemWrite),
    .PCWriteCond(PCWriteCond)
  );

  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {MemRead, ALUSrcA, IorD, IRWrite, ALUSrcB, ALUOp,
                PCWrite, PCSource, MemToReg, RegWrite, RegDst, MemWrite, PCWriteCond};

  // Expected vectors per state, written out from the state descriptions
  localparam logic [14:0] V_ZERO   = 15'd0;
  localparam logic [14:0] V_FETCH  = {1'b1,1'b0,1'b0,1'b1,2'b01,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [14:0] V_DECODE = {1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [14:0] V_MEMADR = {1'b0,1'b1,1'b0,1'b0,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [14:0] V_MEMRD  = {1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [14:0] V_MEMWB  = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};
  localparam logic [14:0] V_MEMWR  = {1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [14:0] V_EXEC   = {1'b0,1'b1,1'b0,1'b0,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [14:0] V_RWB    = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0};
  localparam logic [14:0] V_BRANCH = {1'b0,1'b1,1'b0,1'b0,2'b00,2'b01,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1};

  typedef struct {
    string       name;
    logic [6:0]  op;
    int          n;
    logic [14:0] exp [5];
  } instr_t;

  instr_t      vec [6];
  logic [14:0] exp_q [$];
  int          total = 0;
  int          bad   = 0;

  function automatic instr_t mk(input string nm, input logic [6:0] op, input int n,
                                input logic [14:0] e0, input logic [14:0] e1,
                                input logic [14:0] e2, input logic [14:0] e3,
                                input logic [14:0] e4);
    instr_t t;
    t.name = nm; t.op = op; t.n = n;
    t.exp[0] = e0; t.exp[1] = e1; t.exp[2] = e2; t.exp[3] = e3; t.exp[4] = e4;
    return t;
  endfunction

  // Pop one expectation and compare it with the outputs, 1 time unit later
  task automatic check(input string nm);
    logic [14:0] e;
    #1;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %b", nm, obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        bad++;
        $display("FAIL %s: got %b want %b", nm, obs, e);
      end
    end
  endtask

  // Precondition: at a falling edge, FSM in FETCH. Leaves the same way.
  task automatic run_instr(input instr_t t);
    for (int k = 0; k < t.n; k++) exp_q.push_back(t.exp[k]);
    check($sformatf("%s c0", t.name));
    OPCode = t.op;  // change opcode only during FETCH
    for (int k = 1; k < t.n; k++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", t.name, k));
    end
    @(negedge clk);
  endtask

  // Count cycles from FETCH to the next FETCH (PCWrite & IRWrite), bounded
  task automatic measure(input string nm, input logic [6:0] op, input int want);
    int cnt;
    bit seen;
    cnt = 0; seen = 1'b0;
    OPCode = op;
    while (!seen && cnt < 10) begin
      @(negedge clk);
      #1;
      cnt++;
      if (PCWrite && IRWrite) seen = 1'b1;
    end
    total++;
    if (!seen || cnt != want) begin
      bad++;
      $display("FAIL cpi_%s: got %0d cycles (seen=%0d) want %0d", nm, cnt, seen, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec[0] = mk("lw",    7'b0000011, 5, V_FETCH, V_DECODE, V_MEMADR, V_MEMRD,  V_MEMWB);
    vec[1] = mk("sw",    7'b0100011, 4, V_FETCH, V_DECODE, V_MEMADR, V_MEMWR,  V_ZERO);
    vec[2] = mk("rtype", 7'b0110011, 4, V_FETCH, V_DECODE, V_EXEC,   V_RWB,    V_ZERO);
    vec[3] = mk("beq",   7'b1100011, 3, V_FETCH, V_DECODE, V_BRANCH, V_ZERO,   V_ZERO);
    vec[4] = mk("ill7f", 7'b1111111, 2, V_FETCH, V_DECODE, V_ZERO,   V_ZERO,   V_ZERO);
    vec[5] = mk("addi",  7'b0010011, 2, V_FETCH, V_DECODE, V_ZERO,   V_ZERO,   V_ZERO);

    // Reset held for 5 cycles: all outputs 0
    rst = 1'b1;
    OPCode = 7'b0000000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_q.push_back(V_ZERO);
      check($sformatf("reset c%0d", i));
    end
    rst = 1'b0;  // FSM sits in FETCH; first run_instr check sees the FETCH vector

    // Table-driven: each instruction's full output sequence
    for (int i = 0; i < 6; i++) run_instr(vec[i]);

    // Back-to-back lw, sw, R-type, beq with per-instruction cycle counts
    measure("lw",    7'b0000011, 5);
    measure("sw",    7'b0100011, 4);
    measure("rtype", 7'b0110011, 4);
    measure("beq",   7'b1100011, 3);
    measure("ill",   7'b1111111, 2);

    // Reset asserted during MEMREAD aborts the lw
    exp_q.push_back(V_FETCH);
    exp_q.push_back(V_DECODE);
    exp_q.push_back(V_MEMADR);
    exp_q.push_back(V_MEMRD);
    check("abort fetch");
    OPCode = 7'b0000011;
    @(negedge clk); check("abort decode");
    @(negedge clk); check("abort memadr");
    @(negedge clk); check("abort memread");
    rst = 1'b1;
    exp_q.push_back(V_ZERO);
    check("abort rst same cycle");
    @(negedge clk);
    exp_q.push_back(V_ZERO);
    check("abort rst next cycle");
    rst = 1'b0;
    // First state after release is FETCH, then a full beq runs normally
    run_instr(vec[3]);
    run_instr(vec[2]);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
